// File: rtl/fp_div_iter.sv
// fp_div_iter: multi-cycle floating-point divider with a START/BUSY/DONE handshake.
// A restoring divider produces one quotient bit per clock. Special operands are
// resolved in a single CHECK cycle.
// Optional feature macro: FPDIV_ROUND_NEAREST_EN selects round-to-nearest-even.
// When the macro is undefined, the quotient is truncated.

module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [EXP_W+MAN_W:0] InputA,
  input  logic [EXP_W+MAN_W:0] InputB,
  output logic [EXP_W+MAN_W:0] AbyB,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 EXC,
  output logic [1:0]           Exception
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 3;
  localparam int CW = $clog2(N + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] ZERO    = EW'(0);
  localparam logic [CW-1:0]        ITER_INIT = CW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_ROUND,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [W-1:0]         a_reg, b_reg;
  logic [N-1:0]         q_reg;
  logic [MAN_W+1:0]     rem_reg;
  logic [CW-1:0]        iter_cnt;
  logic signed [EW-1:0] exp_reg;
  logic                 busy_reg;

  // Field extraction from the latched operands
  logic                 sign_a, sign_b, res_sign;
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     frac_a, frac_b;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign_a   = a_reg[W-1];
  assign sign_b   = b_reg[W-1];
  assign exp_a    = a_reg[W-2:MAN_W];
  assign exp_b    = b_reg[W-2:MAN_W];
  assign frac_a   = a_reg[MAN_W-1:0];
  assign frac_b   = b_reg[MAN_W-1:0];
  assign res_sign = sign_a ^ sign_b;
  assign a_zero   = (exp_a == '0);
  assign b_zero   = (exp_b == '0);
  assign a_inf    = (&exp_a) && (frac_a == '0);
  assign b_inf    = (&exp_b) && (frac_b == '0);
  assign a_nan    = (&exp_a) && (frac_a != '0);
  assign b_nan    = (&exp_b) && (frac_b != '0);

  // Special-operand classification, first match wins
  logic         spec_hit, spec_exc;
  logic [W-1:0] spec_word;
  logic [1:0]   spec_code;

  // Resolve NaN / zero / infinity combinations without running the divider
  always_comb begin
    spec_hit  = 1'b0;
    spec_word = '0;
    spec_exc  = 1'b0;
    spec_code = 2'b00;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_hit  = 1'b1;
      spec_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_exc  = 1'b1;
      spec_code = 2'b11;
    end else if (b_zero) begin
      spec_hit  = 1'b1;
      spec_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_exc  = 1'b1;
      spec_code = 2'b00;
    end else if (a_inf) begin
      spec_hit  = 1'b1;
      spec_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_hit  = 1'b1;
      spec_word = {res_sign, {(W-1){1'b0}}};
    end
  end

  // One restoring step: subtract the divisor when it fits, then shift
  logic [MAN_W:0]   mb;
  logic [MAN_W+1:0] rem_diff, rem_kept;
  logic             rem_ge;

  assign mb       = {1'b1, frac_b};
  assign rem_ge   = (rem_reg >= {1'b0, mb});
  assign rem_diff = rem_reg - {1'b0, mb};
  assign rem_kept = rem_ge ? rem_diff : rem_reg;

  // Normalisation and rounding of the finished quotient
  logic                 q_norm, round_inc, carry, hidden_unused;
  logic [MAN_W:0]       sig;
  logic [MAN_W+1:0]     sig_sum;
  logic [MAN_W-1:0]     frac_rnd;
  logic signed [EW-1:0] exp_adj, exp_fin;

  assign q_norm  = q_reg[N-1];
  assign sig     = q_norm ? q_reg[N-1:2] : q_reg[N-2:1];
  assign exp_adj = q_norm ? exp_reg : exp_reg - ONE;

`ifdef FPDIV_ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard     = q_norm ? q_reg[1] : q_reg[0];
  assign sticky    = (q_norm & q_reg[0]) | (rem_reg != '0);
  assign round_inc = guard & (sticky | sig[0]);
`else
  // Truncation drops everything below the significand, so the last quotient bit is not needed
  logic trunc_unused;
  assign trunc_unused = q_reg[0];
  assign round_inc    = 1'b0;
`endif

  assign sig_sum = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_inc};
  assign {carry, hidden_unused, frac_rnd} = sig_sum;
  assign exp_fin = carry ? exp_adj + ONE : exp_adj;

  logic [W-1:0] rnd_word;
  logic         rnd_exc;
  logic [1:0]   rnd_code;

  // Range check of the rounded exponent: overflow to infinity, underflow to zero
  always_comb begin
    rnd_word = {res_sign, exp_fin[EXP_W-1:0], frac_rnd};
    rnd_exc  = 1'b0;
    rnd_code = 2'b00;
    if (exp_fin >= EXP_TOP) begin
      rnd_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_exc  = 1'b1;
      rnd_code = 2'b10;
    end else if (exp_fin <= ZERO) begin
      rnd_word = {res_sign, {(W-1){1'b0}}};
      rnd_exc  = 1'b1;
      rnd_code = 2'b01;
    end
  end

  // Next-state logic for the handshake and iteration sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = S_CHECK;
      S_CHECK:  state_next = spec_hit ? S_FINISH : S_DIVIDE;
      S_DIVIDE: if (iter_cnt == CW'(1)) state_next = S_ROUND;
      S_ROUND:  state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // Operand capture, divider iteration and result registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      rem_reg   <= '0;
      iter_cnt  <= '0;
      exp_reg   <= '0;
      busy_reg  <= 1'b0;
      AbyB      <= '0;
      EXC       <= 1'b0;
      Exception <= 2'b00;
    end else begin
      busy_reg <= (state != S_IDLE) && (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (START) begin
            a_reg <= InputA;
            b_reg <= InputB;
          end
        end
        S_CHECK: begin
          q_reg    <= '0;
          rem_reg  <= {1'b0, 1'b1, frac_a};
          iter_cnt <= ITER_INIT;
          exp_reg  <= EW'({2'b00, exp_a}) - EW'({2'b00, exp_b}) + BIAS;
          if (spec_hit) begin
            AbyB      <= spec_word;
            EXC       <= spec_exc;
            Exception <= spec_code;
          end
        end
        S_DIVIDE: begin
          q_reg    <= {q_reg[N-2:0], rem_ge};
          rem_reg  <= rem_kept << 1;
          iter_cnt <= iter_cnt - CW'(1);
        end
        S_ROUND: begin
          AbyB      <= rnd_word;
          EXC       <= rnd_exc;
          Exception <= rnd_code;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign DONE = (state == S_FINISH);

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed self-checking bench for fp_div_iter (single precision).
// Expected quotients are hand-computed IEEE-754 single-precision constants.

module tb_fp_div_iter;

  logic        CLOCK, RESET, START;
  logic [31:0] InputA, InputB, AbyB;
  logic        BUSY, DONE, EXC;
  logic [1:0]  Exception;

  int checks = 0;
  int errors = 0;

  localparam int NORM_LAT = 28;

`ifdef FPDIV_ROUND_NEAREST_EN
  localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAB;
  localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAB;
`else
  localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAA;
  localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAA;
`endif

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .START(START),
    .InputA(InputA),
    .InputB(InputB),
    .AbyB(AbyB),
    .BUSY(BUSY),
    .DONE(DONE),
    .EXC(EXC),
    .Exception(Exception)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Issue one request and wait (bounded) for DONE.
  // The latency is counted in edges after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output logic [1:0] code,
                        output int lat, output int busy_cycles, output bit timed_out);
    @(posedge CLOCK); #1;
    InputA = a;
    InputB = b;
    START  = 1'b1;
    @(posedge CLOCK); #1;
    START  = 1'b0;
    InputA = 32'hDEADBEEF;
    InputB = 32'h12345678;
    lat = 0; busy_cycles = 0; timed_out = 1'b1;
    res = '0; exc = 1'b0; code = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLOCK); #1;
      lat++;
      if (BUSY) busy_cycles++;
      if (DONE) begin
        timed_out = 1'b0;
        res  = AbyB;
        exc  = EXC;
        code = Exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; InputA = '0; InputB = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    checks++; if (AbyB !== 32'h0) begin errors++; $display("[TB] FAIL reset_abyb: got %h want %h", AbyB, 32'h0); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", DONE); end
    checks++; if (EXC !== 1'b0) begin errors++; $display("[TB] FAIL reset_exc: got %b want 0", EXC); end
    checks++; if (Exception !== 2'b00) begin errors++; $display("[TB] FAIL reset_code: got %b want 00", Exception); end
    RESET = 1'b0;
  endtask

  task automatic test_divide();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [31:0] tq [5];
    logic [31:0] res; logic exc; logic [1:0] code; int lat, busy; bit tmo;
    ta = '{32'h40C00000, 32'hC0F00000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    tb = '{32'h40000000, 32'h40200000, 32'h40000000, 32'h40400000, 32'h3FC00000};
    tq = '{32'h40400000, 32'hC0400000, 32'h3F000000, ONE_THIRD,    TWO_THIRDS};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], res, exc, code, lat, busy, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("[TB] FAIL div_timeout[%0d]: no DONE within bound", i); end
      checks++; if (res !== tq[i]) begin errors++; $display("[TB] FAIL div_result[%0d]: got %h want %h", i, res, tq[i]); end
      checks++; if (exc !== 1'b0 || code !== 2'b00) begin errors++; $display("[TB] FAIL div_exc[%0d]: got %b/%b want 0/00", i, exc, code); end
      checks++; if (lat != NORM_LAT) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d want %0d", i, lat, NORM_LAT); end
      checks++; if (busy != NORM_LAT) begin errors++; $display("[TB] FAIL div_busy[%0d]: got %0d want %0d", i, busy, NORM_LAT); end
      @(posedge CLOCK); #1;
      checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL div_done_pulse[%0d]: got %b want 0", i, DONE); end
      checks++; if (AbyB !== tq[i]) begin errors++; $display("[TB] FAIL div_hold[%0d]: got %h want %h", i, AbyB, tq[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [31:0] tq [8];
    logic        te [8];
    logic [1:0]  tc [8];
    logic [31:0] res; logic exc; logic [1:0] code; int lat, busy; bit tmo;
    ta = '{32'hBF800000, 32'h7FC00000, 32'h00000000, 32'h7F800000,
           32'h7F800000, 32'h40000000, 32'h80000000, 32'h00400000};
    tb = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'hFF800000,
           32'hC0000000, 32'hFF800000, 32'h40A00000, 32'h3F800000};
    tq = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
           32'hFF800000, 32'h80000000, 32'h80000000, 32'h00000000};
    te = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tc = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], res, exc, code, lat, busy, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("[TB] FAIL spec_timeout[%0d]: no DONE within bound", i); end
      checks++; if (res !== tq[i]) begin errors++; $display("[TB] FAIL spec_result[%0d]: got %h want %h", i, res, tq[i]); end
      checks++; if (exc !== te[i]) begin errors++; $display("[TB] FAIL spec_exc[%0d]: got %b want %b", i, exc, te[i]); end
      checks++; if (code !== tc[i]) begin errors++; $display("[TB] FAIL spec_code[%0d]: got %b want %b", i, code, tc[i]); end
      // Special results are registered on the first edge after the accept edge
      checks++; if (lat != 1) begin errors++; $display("[TB] FAIL spec_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] tq [4];
    logic [1:0]  tc [4];
    logic [31:0] res; logic exc; logic [1:0] code; int lat, busy; bit tmo;
    ta = '{32'h7F000000, 32'hFF000000, 32'h00800000, 32'h80800000};
    tb = '{32'h3E800000, 32'h3E800000, 32'h40000000, 32'h40000000};
    tq = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000};
    tc = '{2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], res, exc, code, lat, busy, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("[TB] FAIL range_timeout[%0d]: no DONE within bound", i); end
      checks++; if (res !== tq[i]) begin errors++; $display("[TB] FAIL range_result[%0d]: got %h want %h", i, res, tq[i]); end
      checks++; if (exc !== 1'b1 || code !== tc[i]) begin errors++; $display("[TB] FAIL range_exc[%0d]: got %b/%b want 1/%b", i, exc, code, tc[i]); end
      checks++; if (lat != NORM_LAT) begin errors++; $display("[TB] FAIL range_latency[%0d]: got %0d want %0d", i, lat, NORM_LAT); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic exc; logic [1:0] code; int lat, busy; bit tmo;
    bit seen_done;
    @(posedge CLOCK); #1;
    InputA = 32'h40C00000; InputB = 32'h40000000; START = 1'b1;
    @(posedge CLOCK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLOCK);
    #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy: got %b want 1", BUSY); end
    RESET = 1'b1;
    #1;
    checks++; if (AbyB !== 32'h0) begin errors++; $display("[TB] FAIL midop_abyb: got %h want %h", AbyB, 32'h0); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midop_busy_rst: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL midop_done_rst: got %b want 0", DONE); end
    checks++; if (EXC !== 1'b0 || Exception !== 2'b00) begin errors++; $display("[TB] FAIL midop_exc_rst: got %b/%b want 0/00", EXC, Exception); end
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLOCK); #1;
      if (DONE) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL midop_no_done: got %b want 0", seen_done); end
    run_op(32'h40C00000, 32'h40000000, res, exc, code, lat, busy, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("[TB] FAIL midop_restart_timeout: no DONE within bound"); end
    checks++; if (res !== 32'h40400000) begin errors++; $display("[TB] FAIL midop_restart_result: got %h want %h", res, 32'h40400000); end
    checks++; if (lat != NORM_LAT) begin errors++; $display("[TB] FAIL midop_restart_latency: got %0d want %0d", lat, NORM_LAT); end
  endtask

  // START held high with operands changing every cycle.
  // Operands are accepted at edge 0, then after 28 edges to DONE, a FINISH cycle and an IDLE cycle (edge 30).
  task automatic test_back_to_back();
    int          done_edge [16];
    logic [31:0] done_res  [16];
    int          n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      done_edge[i] = -1;
      done_res[i]  = '0;
    end
    @(posedge CLOCK); #1;
    for (int c = 0; c < 80; c++) begin
      if (c == 0) begin
        InputA = 32'h40C00000; InputB = 32'h40000000;
      end else if (c == 30) begin
        InputA = 32'h3F800000; InputB = 32'h40000000;
      end else begin
        InputA = 32'h3F800000 + c; InputB = 32'h7FC00000;
      end
      START = 1'b1;
      @(posedge CLOCK); #1;
      if (DONE && n < 16) begin
        done_edge[n] = c;
        done_res[n]  = AbyB;
        n++;
      end
    end
    START = 1'b0;
    checks++; if (done_edge[0] != NORM_LAT) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d want %0d", done_edge[0], NORM_LAT); end
    checks++; if (done_res[0] !== 32'h40400000) begin errors++; $display("[TB] FAIL b2b_first_result: got %h want %h", done_res[0], 32'h40400000); end
    checks++; if (done_edge[1] - done_edge[0] != NORM_LAT + 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", done_edge[1] - done_edge[0], NORM_LAT + 2); end
    checks++; if (done_res[1] !== 32'h3F000000) begin errors++; $display("[TB] FAIL b2b_second_result: got %h want %h", done_res[1], 32'h3F000000); end
    checks++; if (done_edge[2] - done_edge[1] != 3) begin errors++; $display("[TB] FAIL b2b_special_spacing: got %0d want 3", done_edge[2] - done_edge[1]); end
    checks++; if (done_res[2] !== 32'h7FC00000) begin errors++; $display("[TB] FAIL b2b_third_result: got %h want %h", done_res[2], 32'h7FC00000); end
  endtask

  // Runs every scenario in order, then prints the summary line
  initial begin
    RESET = 1'b1; START = 1'b0; InputA = '0; InputB = '0;
    $display("[TB] fp_div_iter bench start");
    test_reset();
    test_divide();
    test_specials();
    test_range();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
